// File: rtl/ldl_round_pkg.sv
// ldl_round_pkg: shared types and constants for the round arbiter family.
// Holds the two-state arbiter FSM encoding and the value that stands in
// for a programmed weight of zero.

package ldl_round_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // A weight of zero still grants one packet per turn
    localparam int WEIGHT_ZERO_SUB = 1;

endpackage

// File: rtl/ldl_round_pick.sv
// ldl_round_pick: combinational rotating first-one finder.
// Scans req upward starting at ptr, wrapping modulo REQ_WIDTH, and returns
// the first set position as one-hot and binary, plus an any-request flag.
// Shared by the round arbiters.

module ldl_round_pick
    import ldl_round_pkg::*;
#(
    parameter int BIN_WIDTH = 3,
    parameter int REQ_WIDTH = 1 << BIN_WIDTH
) (
    input  logic [REQ_WIDTH-1:0] req,
    input  logic [BIN_WIDTH-1:0] ptr,
    output logic [REQ_WIDTH-1:0] hot,
    output logic [BIN_WIDTH-1:0] bin,
    output logic                 any
);

    logic [BIN_WIDTH-1:0] idx;

    // Walk positions ptr, ptr+1, ... and keep the first requester seen
    always_comb begin
        hot = '0;
        bin = '0;
        any = 1'b0;
        idx = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            idx = ptr + BIN_WIDTH'(i);
            if (!any && req[idx]) begin
                any = 1'b1;
                bin = idx;
            end
        end
        if (any) begin
            hot[bin] = 1'b1;
        end
    end

endmodule

// File: rtl/ldl_round_wrr.sv
// ldl_round_wrr: weighted round-robin packet arbiter.
// Holds the grant for a whole packet and lets a requester keep it for up to
// its weight of consecutive packets before the pointer moves on.
// Optional macro LDL_ROUND_WRR_NOBUBBLE_EN: re-pick in the end-of-turn cycle
// so the next grant follows without an idle bubble.

module ldl_round_wrr
    import ldl_round_pkg::*;
#(
    parameter int BIN_WIDTH = 3,
    parameter int REQ_WIDTH = 1 << BIN_WIDTH,
    parameter int WGT_WIDTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [REQ_WIDTH-1:0]                req,
    input  logic [REQ_WIDTH-1:0][WGT_WIDTH-1:0] weight,
    input  logic                                last,
    input  logic                                ready,
    output logic [REQ_WIDTH-1:0]                hot,
    output logic [BIN_WIDTH-1:0]                bin,
    output logic                                valid
);

    state_t               state;
    state_t               state_nxt;
    logic [BIN_WIDTH-1:0] ptr;
    logic [BIN_WIDTH-1:0] ptr_nxt;
    logic [WGT_WIDTH-1:0] cnt;
    logic [WGT_WIDTH-1:0] cnt_nxt;
    logic [REQ_WIDTH-1:0] hot_nxt;
    logic [BIN_WIDTH-1:0] bin_nxt;
    logic                 valid_nxt;

    logic [BIN_WIDTH-1:0] pick_ptr;
    logic [REQ_WIDTH-1:0] pick_hot;
    logic [BIN_WIDTH-1:0] pick_bin;
    logic                 pick_any;
    logic [WGT_WIDTH-1:0] load_cnt;
    logic                 beat_last;
    logic                 keep_turn;

    // While busy the picker already looks from the slot after the holder,
    // which is exactly where the pointer lands at end of turn
    assign pick_ptr  = (state == BUSY) ? bin + BIN_WIDTH'(1) : ptr;
    assign load_cnt  = (weight[pick_bin] == '0) ? WGT_WIDTH'(WEIGHT_ZERO_SUB)
                                                : weight[pick_bin];
    assign beat_last = valid && ready && last;
    assign keep_turn = (cnt > WGT_WIDTH'(1)) && req[bin];

    ldl_round_pick #(
        .BIN_WIDTH (BIN_WIDTH),
        .REQ_WIDTH (REQ_WIDTH)
    ) u_pick (
        .req (req),
        .ptr (pick_ptr),
        .hot (pick_hot),
        .bin (pick_bin),
        .any (pick_any)
    );

    // Next-state: grant in IDLE, spend credit or end the turn on the last beat
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        hot_nxt   = hot;
        bin_nxt   = bin;
        valid_nxt = valid;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = BUSY;
                    hot_nxt   = pick_hot;
                    bin_nxt   = pick_bin;
                    cnt_nxt   = load_cnt;
                    valid_nxt = 1'b1;
                end
            end
            BUSY: begin
                if (beat_last) begin
                    if (keep_turn) begin
                        cnt_nxt = cnt - WGT_WIDTH'(1);
                    end else begin
                        ptr_nxt = bin + BIN_WIDTH'(1);
`ifdef LDL_ROUND_WRR_NOBUBBLE_EN
                        if (pick_any) begin
                            hot_nxt   = pick_hot;
                            bin_nxt   = pick_bin;
                            cnt_nxt   = load_cnt;
                        end else begin
                            state_nxt = IDLE;
                            hot_nxt   = '0;
                            valid_nxt = 1'b0;
                        end
`else
                        state_nxt = IDLE;
                        hot_nxt   = '0;
                        valid_nxt = 1'b0;
`endif
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                hot_nxt   = '0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // State and registered grant outputs; reset aborts any packet in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            hot   <= '0;
            bin   <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            hot   <= hot_nxt;
            bin   <= bin_nxt;
            valid <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_ldl_round_wrr.sv
// tb_ldl_round_wrr: self-checking bench for ldl_round_wrr.
// Expected grants come from a packet-level pointer/credit model and are
// queued when stimulus is set up; each accepted beat is checked against the
// head of the queue and the last beat of a packet retires it.

module tb_ldl_round_wrr;

    logic            clk;
    logic            rst_n;
    logic [7:0]      req;
    logic [7:0][3:0] weight;
    logic            last;
    logic            ready;
    logic [7:0]      hot;
    logic [2:0]      bin;
    logic            valid;

    int vectors;
    int miscompares;
    int sb_q[$];

    int m_ptr;
    int m_cur;
    int m_cnt;
    bit m_active;

`ifdef LDL_ROUND_WRR_NOBUBBLE_EN
    localparam bit NOBUBBLE = 1'b1;
`else
    localparam bit NOBUBBLE = 1'b0;
`endif

    ldl_round_wrr #(
        .BIN_WIDTH (3),
        .REQ_WIDTH (8),
        .WGT_WIDTH (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .weight (weight),
        .last   (last),
        .ready  (ready),
        .hot    (hot),
        .bin    (bin),
        .valid  (valid)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something never terminates
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Packet-level reference: push n expected grants for a steady req/weight
    task automatic predict(input int n, input logic [7:0] reqv, input logic [31:0] wv);
        bit found;
        int idx;
        int w;
        for (int p = 0; p < n; p++) begin
            if (!m_active) begin
                found = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    idx = (m_ptr + i) % 8;
                    if (!found && reqv[idx]) begin
                        found = 1'b1;
                        m_cur = idx;
                    end
                end
                w = int'(wv[m_cur*4 +: 4]);
                m_cnt = (w == 0) ? 1 : w;
                m_active = 1'b1;
            end
            sb_q.push_back(m_cur);
            if (m_cnt > 1 && reqv[m_cur]) begin
                m_cnt--;
            end else begin
                m_ptr = (m_cur + 1) % 8;
                m_active = 1'b0;
            end
        end
    endtask

    task automatic applyReset(input logic [7:0] r, input logic [31:0] w);
        rst_n = 1'b0;
        ready = 1'b0;
        last  = 1'b0;
        req   = r;
        weight = w;
        sb_q.delete();
        m_ptr = 0;
        m_cur = 0;
        m_cnt = 0;
        m_active = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(valid), 0);
        checkOutput("rst_hot", 32'(hot), 0);
        checkOutput("rst_bin", 32'(bin), 0);
        rst_n = 1'b1;
    endtask

    // Drive one cycle, score any accepted beat, then advance past the edge
    task automatic applyStimulus(input logic [7:0] r, input logic rdy, input logic lst,
                                 output bit acc, output bit acc_last);
        req   = r;
        ready = rdy;
        last  = lst;
        acc      = valid && ready;
        acc_last = acc && last;
        if (acc) begin
            if (sb_q.size() == 0) begin
                checkOutput("sb_has_entry", 32'(sb_q.size()), 1);
            end else begin
                checkOutput("beat_bin", 32'(bin), 32'(sb_q[0]));
                checkOutput("beat_hot", 32'(hot), 32'(1) << sb_q[0]);
                if (lst) void'(sb_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic runPackets(input int beats, input bit toggle, input int budget);
        int bc;
        int cyc;
        bit acc;
        bit accl;
        bc  = 0;
        cyc = 0;
        while (sb_q.size() > 0 && cyc < budget) begin
            applyStimulus(req, toggle ? (cyc % 2 == 0) : 1'b1, bc == beats - 1, acc, accl);
            if (accl) bc = 0;
            else if (acc) bc++;
            cyc++;
        end
        ready = 1'b0;
        last  = 1'b0;
        checkOutput("sb_drained", 32'(sb_q.size()), 0);
    endtask

    initial begin
        bit acc;
        bit accl;
        int ncyc;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        req = '0;
        weight = '0;
        last = 1'b0;
        ready = 1'b0;

        $display("[TB] test 1: reset release, all requesters");
        applyReset(8'hFF, 32'h1111_1111);
        predict(10, 8'hFF, 32'h1111_1111);
        applyStimulus(8'hFF, 1'b1, 1'b1, acc, accl);
        checkOutput("first_valid", 32'(valid), 1);
        checkOutput("first_bin", 32'(bin), 0);
        runPackets(1, 1'b0, 200);

        $display("[TB] test 2: bubble between turns");
        applyReset(8'h05, 32'h1111_1111);
        predict(4, 8'h05, 32'h1111_1111);
        applyStimulus(8'h05, 1'b1, 1'b1, acc, accl);
        ncyc = NOBUBBLE ? 4 : 8;
        for (int k = 0; k < ncyc; k++) begin
            checkOutput("bubble_valid", 32'(valid), NOBUBBLE ? 1 : ((k % 2 == 0) ? 1 : 0));
            applyStimulus(8'h05, 1'b1, 1'b1, acc, accl);
        end
        ready = 1'b0;
        checkOutput("sb_drained", 32'(sb_q.size()), 0);

        $display("[TB] test 3: weighting, weight 0 acts as 1");
        applyReset(8'h18, 32'h1110_3111);
        predict(7, 8'h18, 32'h1110_3111);
        runPackets(1, 1'b0, 200);

        $display("[TB] test 4: multi-beat hold with ready toggling");
        applyReset(8'hFE, 32'h1111_1111);
        predict(3, 8'hFE, 32'h1111_1111);
        runPackets(4, 1'b1, 200);

        $display("[TB] test 5: early request drop ends the turn");
        applyReset(8'h60, 32'h1131_1111);
        sb_q.push_back(5);
        sb_q.push_back(6);
        applyStimulus(8'h60, 1'b1, 1'b0, acc, accl);
        applyStimulus(8'h60, 1'b1, 1'b0, acc, accl);
        applyStimulus(8'h41, 1'b1, 1'b1, acc, accl);
        runPackets(1, 1'b0, 20);

        $display("[TB] test 6: async reset mid-packet");
        applyReset(8'h40, 32'h1211_1111);
        predict(1, 8'h40, 32'h1211_1111);
        applyStimulus(8'h40, 1'b1, 1'b0, acc, accl);
        applyStimulus(8'h40, 1'b1, 1'b0, acc, accl);
        applyStimulus(8'h40, 1'b1, 1'b0, acc, accl);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_valid", 32'(valid), 0);
        checkOutput("async_hot", 32'(hot), 0);
        checkOutput("async_bin", 32'(bin), 0);
        sb_q.delete();
        m_ptr = 0;
        m_active = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        predict(2, 8'h40, 32'h1211_1111);
        applyStimulus(8'h40, 1'b1, 1'b0, acc, accl);
        checkOutput("regrant_valid", 32'(valid), 1);
        checkOutput("regrant_bin", 32'(bin), 6);
        applyStimulus(8'h40, 1'b1, 1'b1, acc, accl);
        checkOutput("credit_valid", 32'(valid), 1);
        applyStimulus(8'h40, 1'b1, 1'b1, acc, accl);
        checkOutput("turn_end_valid", 32'(valid), NOBUBBLE ? 1 : 0);
        ready = 1'b0;
        last  = 1'b0;
        checkOutput("sb_drained", 32'(sb_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ldl_round_wrr.md
# ldl_round_wrr

Weighted round-robin packet arbiter for the round family. It grants a shared downstream port to one of REQ_WIDTH requesters and holds the grant for a whole packet, which can span several beats. A requester may keep the grant for up to its programmed weight of consecutive packets before the pointer moves on. It sits between requesting queues and a shared link, where plain per-beat round-robin would interleave packets.

## Interface
- BIN_WIDTH, 3, binary index width.
- REQ_WIDTH, 1 << BIN_WIDTH, number of requesters.
- WGT_WIDTH, 4, weight and credit width.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low (0 is reset).
- req  input  REQ_WIDTH  per-requester request; held high until that requester's last beat is accepted.
- weight  input  REQ_WIDTH x WGT_WIDTH  packets per turn; 0 is treated as 1; sampled at grant time.
- last  input  1  marks the final beat of the current packet; qualified by valid && ready.
- ready  input  1  downstream accepts a beat.
- hot  output  REQ_WIDTH  registered one-hot grant.
- bin  output  BIN_WIDTH  registered binary grant index.
- valid  output  1  registered; high while a grant is held.

## Operation
- State machine: IDLE and BUSY. Internal registers: ptr (BIN_WIDTH bits) and cnt (WGT_WIDTH bits).
- **Pick:** scan req starting at ptr upward, wrapping modulo REQ_WIDTH. The first set bit wins.
- **IDLE:** if any req is set, register hot/bin for the winner, load cnt = max(weight[winner], 1), and go to BUSY. Otherwise stay in IDLE.
- **BUSY:** valid=1. A beat transfers when valid && ready. Beats without last change nothing.
- **End of packet** (beat with last), in this priority order:
  - If cnt > 1 and req[bin] is high in the same cycle: cnt -= 1 and the grant stays on bin.
  - Otherwise: ptr = (bin + 1) mod REQ_WIDTH, then the end-of-turn action below applies.
- **End-of-turn action** depends on configuration (see Configuration).
- req changes during a packet have no effect on the current grant. Deassertion of req[bin] is observed only at the last beat.
- ptr wrap: bin = REQ_WIDTH-1 gives ptr = 0.
- Reset: hot=0, bin=0, valid=0, ptr=0, cnt=0, state IDLE. Asserting reset mid-packet clears everything immediately. The aborted packet is not resumed.

## Timing
- Request to grant: 1 cycle. req sampled in IDLE at cycle t gives valid=1 at t+1.
- Throughput is one beat per cycle while ready=1.
- Turn change without the macro: last accepted at t, valid=0 at t+1, next grant valid at t+2.
- Turn change with the macro: next grant valid at t+1.
- Credit continuation (same requester keeps the grant) never drops valid.
- valid, hot and bin change only on the rising edge of clk or on asynchronous reset. They never depend combinationally on ready or last.

## Configuration
- `LDL_ROUND_WRR_NOBUBBLE_EN` defined: at end of turn, pick is evaluated in the same cycle on req with the new ptr. If there is a winner, load it and its cnt and stay in BUSY. If not, go to IDLE.
- Not defined: end of turn always goes to IDLE, inserting one bubble cycle between turns.
- Both builds produce identical grant order.

## Structure
- Package ldl_round_pkg holds the state enum typedef (IDLE, BUSY) and a shared constant for the weight-0 substitute value (1).
- Sub-module ldl_round_pick: combinational rotating first-one finder.
  - Inputs: req, ptr.
  - Outputs: hot, bin, any.
  - Instantiated once.
  - Reusable by the other round arbiters.

## Test plan
1. Reset release with req=8'hFF, weights 1, ready=1, last=1:
   - During reset: valid=0, hot=0, bin=0.
   - After release: first grant bin=0 one cycle later, then bin=1, 2, and so on.
2. Bubble check with req=8'b0000_0101, weights 1, single-beat packets:
   - Grants alternate bin 0, 2, 0, 2.
   - valid pattern without the macro: 1,0,1,0.
   - valid pattern with `LDL_ROUND_WRR_NOBUBBLE_EN`: continuous 1.
3. Weighting with req=8'h18, weight[3]=3, weight[4]=0, single-beat packets:
   - Three consecutive grants to bin 3, then one to bin 4 (weight 0 acts as 1), then back to bin 3.
4. Multi-beat hold: 4-beat packet from requester 1, ready toggling 1,0,1,0…, other reqs high:
   - bin stays 1 until the 4th accepted beat with last.
   - Then ptr=2 and the next grant goes to requester 2.
5. Early drop: weight[5]=3, req[5] drops before the first packet's last beat:
   - The turn ends after one packet; ptr=6.
6. Async reset mid-packet (beat 2 of 4, bin=6):
   - hot, bin and valid go to 0 without waiting for clk.
   - After release with req=8'h40: grant bin=6, cnt reloaded.
